// File: rtl/tdm_demux_2x4_pkg.sv
// ----------------------------------------------------------------------------
// tdm_demux_2x4_pkg
// Shared definitions for the 2-channel, 4-slot TDM demultiplexer:
//   state_t : frame FSM states (IDLE = waiting for first sync, RUN = locked)
//   SLOT_W  : width of the slot index
//   SLOTS   : TDM slots per frame
// ----------------------------------------------------------------------------
package tdm_demux_2x4_pkg;

   localparam int SLOT_W = 2;
   localparam int SLOTS  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : tdm_demux_2x4_pkg

// File: rtl/tdm_demux_2x4_if.sv
// ----------------------------------------------------------------------------
// tdm_demux_2x4_if
// Bus bundle between the TDM source/sink and the demultiplexer.
//   sync        : frame start marker (current cycle is slot 0)
//   d1, d2      : serial TDM data per channel
//   gn1, gn2    : active-low channel enables
//   y1, y2      : demultiplexed words, bit k = slot k
//   vld1, vld2  : one-cycle pulse when the matching y word was just loaded
//   slot        : slot index the next clock edge will sample
//   err         : one-cycle pulse on a misplaced sync
// Modports: master drives the TDM inputs, slave is the demultiplexer.
// ----------------------------------------------------------------------------
interface tdm_demux_2x4_if;
   import tdm_demux_2x4_pkg::*;

   logic              sync;
   logic              d1;
   logic              d2;
   logic              gn1;
   logic              gn2;
   logic [SLOTS-1:0]  y1;
   logic [SLOTS-1:0]  y2;
   logic              vld1;
   logic              vld2;
   logic [SLOT_W-1:0] slot;
   logic              err;

   modport master (
      output sync, d1, d2, gn1, gn2,
      input  y1, y2, vld1, vld2, slot, err
   );

   modport slave (
      input  sync, d1, d2, gn1, gn2,
      output y1, y2, vld1, vld2, slot, err
   );

endinterface : tdm_demux_2x4_if

// File: rtl/tdm_demux_2x4_lane.sv
// ----------------------------------------------------------------------------
// tdm_demux_lane
// One demultiplexer channel: collects slot bits into a shadow register,
// tracks whether the whole frame was enabled, and loads the output word on
// the slot-3 sample.
//   clk, rst   : clock, asynchronous active-high reset
//   sample_en  : a slot is sampled on this edge
//   samp_slot  : index of the slot being sampled
//   d, gn      : serial data and active-low enable of this channel
//   y, vld     : registered output word and its one-cycle load pulse
// ----------------------------------------------------------------------------
module tdm_demux_lane
   import tdm_demux_2x4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic [SLOT_W-1:0] samp_slot,
   input  logic              d,
   input  logic              gn,
   output logic [SLOTS-1:0]  y,
   output logic              vld
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   // Only slots 0..2 need storage; the last bit goes straight into y.
   logic [SLOTS-2:0] shadow_reg;
   logic             frame_ok_reg;
   logic [SLOTS-1:0] y_reg;
   logic             vld_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_reg   <= '0;
         frame_ok_reg <= 1'b0;
         y_reg        <= '0;
         vld_reg      <= 1'b0;
      end else begin
         vld_reg <= 1'b0;
         if (sample_en) begin
            if (samp_slot == '0) begin
               // A slot-0 sample starts a fresh frame: wiping the shadow and
               // re-deriving frame_ok discards any partial frame (resync).
               shadow_reg   <= {{(SLOTS-2){1'b0}}, d};
               frame_ok_reg <= ~gn;
            end else begin
               if (gn)
                  frame_ok_reg <= 1'b0;
               if (samp_slot == LAST_SLOT) begin
                  if (frame_ok_reg && !gn) begin
                     y_reg   <= {d, shadow_reg};
                     vld_reg <= 1'b1;
                  end
               end else begin
                  shadow_reg[samp_slot] <= d;
               end
            end
         end
      end
   end

   assign y   = y_reg;
   assign vld = vld_reg;

endmodule : tdm_demux_lane

// File: rtl/tdm_demux_2x4.sv
// ----------------------------------------------------------------------------
// tdm_demux_2x4
// Two-channel TDM demultiplexer, 4 slots per frame. Locks on the first sync,
// then runs free; a sync anywhere but slot 0 restarts the frame and pulses err.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tdm_demux_2x4_if.slave (sync, d1/d2, gn1/gn2 in;
//              y1/y2, vld1/vld2, slot, err out)
// Parameter SLOTS: slots per frame, only 4 is supported.
// ----------------------------------------------------------------------------
module tdm_demux_2x4 #(
   parameter int SLOTS = tdm_demux_2x4_pkg::SLOTS
) (
   input  logic            clk,
   input  logic            rst,
   tdm_demux_2x4_if.slave  bus
);
   import tdm_demux_2x4_pkg::*;

   localparam int                LANES     = 2;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   state_t            state_reg, state_next;
   logic [SLOT_W-1:0] slot_reg, slot_next;
   logic              err_reg, err_next;
   logic              sample_en;
   logic [SLOT_W-1:0] samp_slot;

   logic [LANES-1:0]  d_vec;
   logic [LANES-1:0]  gn_vec;
   logic [SLOTS-1:0]  y_arr [LANES];
   logic [LANES-1:0]  vld_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         slot_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      slot_next  = slot_reg;
      err_next   = 1'b0;
      sample_en  = 1'b0;
      samp_slot  = slot_reg;
      case (state_reg)
         IDLE: begin
            slot_next = '0;
            if (bus.sync) begin
               sample_en  = 1'b1;
               samp_slot  = '0;
               slot_next  = SLOT_W'(1);
               state_next = RUN;
            end
         end
         RUN: begin
            sample_en = 1'b1;
            if (bus.sync) begin
               // Sync always forces this cycle to be slot 0; it is only an
               // error when the counter did not already expect slot 0.
               samp_slot = '0;
               slot_next = SLOT_W'(1);
               err_next  = (slot_reg != '0);
            end else begin
               slot_next = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            slot_next  = '0;
         end
      endcase
   end

   assign d_vec  = {bus.d2, bus.d1};
   assign gn_vec = {bus.gn2, bus.gn1};

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         tdm_demux_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .samp_slot (samp_slot),
            .d         (d_vec[gi]),
            .gn        (gn_vec[gi]),
            .y         (y_arr[gi]),
            .vld       (vld_vec[gi])
         );
      end
   endgenerate

   assign bus.y1   = y_arr[0];
   assign bus.y2   = y_arr[1];
   assign bus.vld1 = vld_vec[0];
   assign bus.vld2 = vld_vec[1];
   assign bus.slot = slot_reg;
   assign bus.err  = err_reg;

endmodule : tdm_demux_2x4

// File: tb/tb_tdm_demux_2x4.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_2x4
// Table-driven bench for tdm_demux_2x4: one vector per clock cycle with the
// outputs expected right after that edge, followed by a hand-written
// asynchronous-reset sequence.
// ----------------------------------------------------------------------------
module tb_tdm_demux_2x4;

   typedef struct {
      logic       sync;
      logic       d1;
      logic       d2;
      logic       gn1;
      logic       gn2;
      logic [3:0] y1;
      logic [3:0] y2;
      logic       vld1;
      logic       vld2;
      logic [1:0] slot;
      logic       err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   vec_t vq[$];

   tdm_demux_2x4_if bus_if ();

   tdm_demux_2x4 #(.SLOTS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic s, a, b, g1, g2,
                               input logic [3:0] ey1, ey2,
                               input logic ev1, ev2,
                               input logic [1:0] es,
                               input logic ee);
      vec_t v;
      v.sync = s;   v.d1 = a;     v.d2 = b;     v.gn1 = g1;   v.gn2 = g2;
      v.y1 = ey1;   v.y2 = ey2;   v.vld1 = ev1; v.vld2 = ev2;
      v.slot = es;  v.err = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic s, a, b, g1, g2);
      bus_if.sync = s;
      bus_if.d1   = a;
      bus_if.d2   = b;
      bus_if.gn1  = g1;
      bus_if.gn2  = g2;
   endtask

   // Drive one cycle of inputs, clock it, settle past the edge.
   task automatic step(input logic s, a, b, g1, g2);
      drive(s, a, b, g1, g2);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ey1, ey2,
                          input logic ev1, ev2, input logic [1:0] es, input logic ee);
      chk({tag, ".y1"},   8'(bus_if.y1),   8'(ey1));
      chk({tag, ".y2"},   8'(bus_if.y2),   8'(ey2));
      chk({tag, ".vld1"}, 8'(bus_if.vld1), 8'(ev1));
      chk({tag, ".vld2"}, 8'(bus_if.vld2), 8'(ev2));
      chk({tag, ".slot"}, 8'(bus_if.slot), 8'(es));
      chk({tag, ".err"},  8'(bus_if.err),  8'(ee));
   endtask

   initial begin
      //                 sync d1 d2 g1 g2   y1    y2    v1 v2 slot err
      // first frame, ch1 word 1101, ch2 disabled
      vq.push_back(mk(1, 1, 0, 0, 1, 4'h0, 4'h0, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'h0, 4'h0, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'hD, 4'h0, 1, 0, 2'd0, 0));
      // free-running frames A then 5, no sync
      vq.push_back(mk(0, 0, 0, 0, 1, 4'hD, 4'h0, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'hD, 4'h0, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 4'hD, 4'h0, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'hA, 4'h0, 1, 0, 2'd0, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'hA, 4'h0, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 4'hA, 4'h0, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 0, 0, 1, 4'hA, 4'h0, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 4'h5, 4'h0, 1, 0, 2'd0, 0));
      // word 6 on both, gn2 high at slot 2 only -> ch2 frame dropped
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h5, 4'h0, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h5, 4'h0, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 1, 0, 1, 4'h5, 4'h0, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h6, 4'h0, 1, 0, 2'd0, 0));
      // next full frame 9 -> ch2 recovers
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h6, 4'h0, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h6, 4'h0, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h6, 4'h0, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h9, 4'h9, 1, 1, 2'd0, 0));
      // sync misplaced at slot 2, new frame 3 from that cycle
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h9, 4'h9, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h9, 4'h9, 0, 0, 2'd2, 0));
      vq.push_back(mk(1, 1, 1, 0, 0, 4'h9, 4'h9, 0, 0, 2'd1, 1));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h9, 4'h9, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h9, 4'h9, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h3, 4'h3, 1, 1, 2'd0, 0));
      // sync at slot 3: error, no load, new frame C
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'h3, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'h3, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'h3, 0, 0, 2'd3, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 4'h3, 4'h3, 0, 0, 2'd1, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'h3, 4'h3, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'h3, 4'h3, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'hC, 4'hC, 1, 1, 2'd0, 0));
      // sync at slot 0 accepted silently, word F
      vq.push_back(mk(1, 1, 1, 0, 0, 4'hC, 4'hC, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'hC, 4'hC, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'hC, 4'hC, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 1, 1, 0, 0, 4'hF, 4'hF, 1, 1, 2'd0, 0));
      // gn1 high at slot 0 only -> ch1 frame invalid, ch2 loads 0
      vq.push_back(mk(0, 0, 0, 1, 0, 4'hF, 4'hF, 0, 0, 2'd1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 2'd2, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 2'd3, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 0, 1, 2'd0, 0));

      // reset state
      drive(0, 0, 0, 1, 1);
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 4'h0, 4'h0, 0, 0, 2'd0, 0);
      $display("reset: slot=%0d y1=%h y2=%h", bus_if.slot, bus_if.y1, bus_if.y2);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].sync, vq[i].d1, vq[i].d2, vq[i].gn1, vq[i].gn2);
         $display("vec %0d: sync=%b d=%b%b gn=%b%b -> slot=%0d y1=%h y2=%h vld=%b%b err=%b",
                  i, vq[i].sync, vq[i].d1, vq[i].d2, vq[i].gn1, vq[i].gn2,
                  bus_if.slot, bus_if.y1, bus_if.y2, bus_if.vld1, bus_if.vld2, bus_if.err);
         chk_all($sformatf("v%0d", i), vq[i].y1, vq[i].y2, vq[i].vld1, vq[i].vld2,
                 vq[i].slot, vq[i].err);
      end

      // asynchronous reset at slot 2 of a frame, between clock edges
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("pre_rst.slot", 8'(bus_if.slot), 8'd2);
      rst = 1'b1;
      #2;
      $display("async rst: slot=%0d y1=%h y2=%h", bus_if.slot, bus_if.y1, bus_if.y2);
      chk_all("async_rst", 4'h0, 4'h0, 0, 0, 2'd0, 0);
      // reset held across an edge with sync high: nothing may move
      drive(1, 1, 1, 0, 0);
      @(posedge clk);
      #1;
      chk_all("rst_hold", 4'h0, 4'h0, 0, 0, 2'd0, 0);
      drive(0, 1, 1, 0, 0);
      rst = 1'b0;

      // no sync after release: stays idle, never pulses vld
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 1, 0, 0);
         $display("idle %0d: slot=%0d vld=%b%b", i, bus_if.slot, bus_if.vld1, bus_if.vld2);
         chk_all($sformatf("idle%0d", i), 4'h0, 4'h0, 0, 0, 2'd0, 0);
      end

      // sync plus four samples: word 1 on both channels
      step(1, 1, 1, 0, 0);
      chk_all("rf0", 4'h0, 4'h0, 0, 0, 2'd1, 0);
      step(0, 0, 0, 0, 0);
      chk_all("rf1", 4'h0, 4'h0, 0, 0, 2'd2, 0);
      step(0, 0, 0, 0, 0);
      chk_all("rf2", 4'h0, 4'h0, 0, 0, 2'd3, 0);
      step(0, 0, 0, 0, 0);
      $display("post-rst frame: y1=%h y2=%h vld=%b%b", bus_if.y1, bus_if.y2, bus_if.vld1, bus_if.vld2);
      chk_all("rf3", 4'h1, 4'h1, 1, 1, 2'd0, 0);
      step(0, 0, 0, 0, 0);
      chk_all("rf4", 4'h1, 4'h1, 0, 0, 2'd1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_tdm_demux_2x4

// File: doc/tdm_demux_2x4.md
TDM_DEMUX_2X4 -- requirements
Module: tdm_demux_2x4

Interface
REQ-001 SHALL have parameter SLOTS, default 4, meaning the number of TDM slots per frame; only the value 4 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port sync, input, 1 bit: frame start; when high, the current cycle is slot 0.
REQ-005 SHALL have ports d1 and d2, input, 1 bit each: serial TDM data for channel 1 and channel 2.
REQ-006 SHALL have ports gn1 and gn2, input, 1 bit each: active-low channel enables.
REQ-007 SHALL have ports y1 and y2, output, 4 bits each: registered demultiplexed words; bit k holds slot k.
REQ-008 SHALL have ports vld1 and vld2, output, 1 bit each: one-cycle pulse, high when the corresponding y word has just been updated.
REQ-009 SHALL have port slot, output, 2 bits: index of the slot the next clock edge will sample.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on a misplaced sync.

Function
REQ-011 SHALL implement an FSM with two states:
- IDLE: waits for sync.
- RUN: samples one slot per cycle.
REQ-012 In IDLE with sync=1, SHALL sample slot 0, set slot to 1 and enter RUN; with sync=0, SHALL stay in IDLE with slot=0.
REQ-013 In RUN, SHALL sample d1/d2 into per-channel shadow bit [slot] and increment slot modulo 4 (3 wraps to 0); the frame is free-running with no sync required after lock.
REQ-014 In RUN, sync=1 when slot=0 SHALL be accepted silently.
REQ-015 In RUN, sync=1 when slot≠0 SHALL:
- pulse err for one cycle;
- discard the partial frame on both channels;
- sample the current cycle as slot 0;
- set slot to 1.
REQ-016 Per channel, a frame_ok flag SHALL be set at the slot-0 sample iff gn=0, and cleared at any slot sampled with gn=1.
REQ-017 On the edge sampling slot 3, if frame_ok=1 and gn=0, SHALL load y with the shadow bits [2:0] plus the current d as bit 3, and assert vld for exactly the following cycle (latency of 1 edge after the last bit).
REQ-018 If a channel's frame is not ok, SHALL hold y and keep vld=0 at the end of that frame; the other channel SHALL be unaffected.
REQ-019 gn deasserting mid-frame SHALL make that frame invalid; the channel resumes with the next frame whose slot 0 is sampled with gn=0.
REQ-020 sync and the slot-3 edge coinciding (sync at slot 3) SHALL be treated as a misplaced sync per REQ-015: no vld, err=1.
REQ-021 y SHALL change only together with a vld pulse.

Reset
REQ-022 While rst=1, asynchronously and regardless of clk, SHALL force:
- state to IDLE;
- slot, y1, y2 and shadows to 0;
- vld1, vld2, err and frame_ok flags to 0.
REQ-023 Reset mid-frame SHALL discard the partial frame, with no vld after release until a full new frame completes.

Structure
REQ-024 SHALL use a shared package holding:
- the state enumeration (IDLE, RUN);
- SLOT_W=2;
- the SLOTS constant.
REQ-025 SHALL place the per-channel shadow, frame_ok, y and vld logic in one sub-module, tdm_demux_lane, instantiated twice; the top holds the FSM, slot counter and err.

Verification
REQ-026 Reset then sync pulse, serial d1=1,0,1,1 over slots 0..3 with gn1=0 -> y1=4'b1101 with vld1=1 for one cycle after the 4th edge; slot sequence 1,2,3,0.
REQ-027 Two back-to-back frames, d1 word 4'hA then 4'h5, sync only on the first -> vld1 pulses 4 cycles apart, y1=4'hA then 4'h5.
REQ-028 gn2=1 during slot 2 only, gn1=0 throughout, d1=d2 pattern 4'h6 -> vld1=1 with y1=4'h6; vld2=0 and y2 holds its old value; the next full frame on ch2 yields vld2.
REQ-029 sync reasserted at slot 2 -> err=1 for one cycle, no vld, new frame counted from that cycle; its 4'h3 completes with vld after 4 edges.
REQ-030 rst asserted at slot 2 mid-frame -> all outputs 0 immediately without a clock edge; after release, no vld until sync plus 4 samples.
